// File: rtl/sw_chrono_pkg.sv
// rtl/sw_chrono_pkg.sv - shared state encoding and seven-segment decode for sw_chrono
// Contents:
//   sw_state_e  : CLEAR/RUN/HOLD/STOP = 0..3, also the command encoding
//   SEG_BLANK   : all segments off (active-low)
//   bcd_to_seg  : BCD digit -> active-low segments {g,f,e,d,c,b,a}
package sw_chrono_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_STOP  = 2'd3
  } sw_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'h40;
      4'd1:    bcd_to_seg = 7'h79;
      4'd2:    bcd_to_seg = 7'h24;
      4'd3:    bcd_to_seg = 7'h30;
      4'd4:    bcd_to_seg = 7'h19;
      4'd5:    bcd_to_seg = 7'h12;
      4'd6:    bcd_to_seg = 7'h02;
      4'd7:    bcd_to_seg = 7'h78;
      4'd8:    bcd_to_seg = 7'h00;
      4'd9:    bcd_to_seg = 7'h10;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// rtl/sw_tick_gen.sv - prescaler producing one tick every DIV enabled cycles
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   en             : advance the prescaler this cycle
//   clr            : force the prescaler back to 0 (wins over en)
//   tick           : high during the terminal prescaler cycle
module sw_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // The tick is not masked by clr so a coincident CLEAR still sees the tick first.
  assign tick = en && (cnt == TERM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sw_chrono.sv
// rtl/sw_chrono.sv - parametrised BCD stopwatch core with HOLD display and optional lap FIFO
// Optional feature macro: SW_CHRONO_LAP_FIFO_EN (lap-time FIFO; absent = no storage)
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   cmd_valid, cmd[1:0]   : one-cycle command strobe, 0 CLEAR 1 RUN 2 HOLD 3 STOP
//   lap_rd                : pop oldest lap entry
//   digits, seg_n         : displayed BCD value and its active-low segment decode
//   state, state_led      : current state (encoded as cmd) and one-hot indicator
//   wrap                  : one-cycle pulse when the count rolls to all zeros
//   lap_data, lap_count   : show-ahead oldest lap, number of stored laps
//   lap_empty, lap_full   : FIFO flags
module sw_chrono
  import sw_chrono_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 10,
  parameter int DIGITS    = 4,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  input  logic [1:0]                     cmd,
  input  logic                           lap_rd,
  output logic [4*DIGITS-1:0]            digits,
  output logic [7*DIGITS-1:0]            seg_n,
  output logic [1:0]                     state,
  output logic [3:0]                     state_led,
  output logic                           wrap,
  output logic [4*DIGITS-1:0]            lap_data,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_empty,
  output logic                           lap_full
);

  localparam int CW = $clog2(LAP_DEPTH + 1);

  sw_state_e           st, nxt, cmd_e;
  logic                tick, carry;
  logic [4*DIGITS-1:0] cnt_q, cnt_inc, cnt_nxt;

  assign cmd_e = sw_state_e'(cmd);
  assign state = st;

  always_comb begin
    nxt = st;
    if (cmd_valid) begin
      case (st)
        ST_CLEAR: if (cmd_e == ST_RUN)  nxt = cmd_e;
        ST_RUN:   if (cmd_e != ST_RUN)  nxt = cmd_e;
        ST_HOLD:  if (cmd_e != ST_HOLD) nxt = cmd_e;
        default:  if (cmd_e == ST_RUN || cmd_e == ST_CLEAR) nxt = cmd_e;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st        <= ST_CLEAR;
      state_led <= 4'b0001;
    end else begin
      st        <= nxt;
      state_led <= 4'b0001 << nxt;
    end
  end

  // Prescaler runs on the current state, so a tick coincident with a command
  // is applied under the old state before the new one takes effect.
  sw_tick_gen #(.DIV(CLK_HZ / TICK_HZ)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (st == ST_RUN || st == ST_HOLD),
    .clr     (nxt == ST_CLEAR),
    .tick    (tick)
  );

  // BCD ripple increment; carry out of the top digit means all-9s rolled over.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign cnt_nxt = (nxt == ST_CLEAR) ? '0 : (tick ? cnt_inc : cnt_q);

  // The display follows cnt_nxt so it tracks the count without lag; it stops
  // loading on entry to HOLD, keeping the value the count had in that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      digits <= '0;
      wrap   <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      wrap  <= tick && carry;
      if (nxt != ST_HOLD) digits <= cnt_nxt;
    end
  end

  always_comb begin
    seg_n = '0;
    for (int i = 0; i < DIGITS; i++) seg_n[7*i +: 7] = bcd_to_seg(digits[4*i +: 4]);
  end

`ifdef SW_CHRONO_LAP_FIFO_EN
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  logic [4*DIGITS-1:0] mem [LAP_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       fill;
  logic                lap_push, flush, do_push, do_pop;

  assign lap_push = (st == ST_RUN) && (nxt == ST_HOLD);
  assign flush    = (nxt == ST_CLEAR);
  assign do_pop   = lap_rd && (fill != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push  = lap_push && (!lap_full || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= cnt_q;
  end

  assign lap_count = fill;
  assign lap_empty = (fill == '0);
  assign lap_full  = (fill == CW'(LAP_DEPTH));
  assign lap_data  = lap_empty ? '0 : mem[rd_ptr];
`else
  logic lap_unused;
  assign lap_unused = lap_rd;
  assign lap_data   = '0;
  assign lap_count  = '0;
  assign lap_empty  = 1'b1;
  assign lap_full   = 1'b0;
`endif

endmodule

// File: tb/tb_sw_chrono.sv
// tb/tb_sw_chrono.sv - scoreboard testbench for sw_chrono (CLK_HZ=100, TICK_HZ=10)
module tb_sw_chrono;
  import sw_chrono_pkg::*;

  localparam logic [27:0] SEG_ZERO = {4{7'h40}};

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid, lap_rd, cmd2_valid, lap_rd2;
  logic [1:0]  cmd, cmd2;

  logic [15:0] digits, lap_data;
  logic [27:0] seg_n;
  logic [1:0]  state, state2;
  logic [3:0]  state_led, state_led2;
  logic        wrap, lap_empty, lap_full;
  logic [2:0]  lap_count, lap_count2;
  logic [7:0]  digits2, lap_data2;
  logic [13:0] seg_n2;
  logic        wrap2, lap_empty2, lap_full2;

  always #5 clock = ~clock;

  sw_chrono #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(4), .LAP_DEPTH(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd), .lap_rd(lap_rd),
    .digits(digits), .seg_n(seg_n), .state(state), .state_led(state_led), .wrap(wrap),
    .lap_data(lap_data), .lap_count(lap_count), .lap_empty(lap_empty), .lap_full(lap_full)
  );

  // Two-digit instance so the all-9s rollover is reachable in a short run.
  sw_chrono #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(2), .LAP_DEPTH(4)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd2_valid), .cmd(cmd2), .lap_rd(lap_rd2),
    .digits(digits2), .seg_n(seg_n2), .state(state2), .state_led(state_led2), .wrap(wrap2),
    .lap_data(lap_data2), .lap_count(lap_count2), .lap_empty(lap_empty2), .lap_full(lap_full2)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  logic [31:0] act;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       actual = 32'(digits);
      1:       actual = 32'(seg_n);
      2:       actual = 32'(state);
      3:       actual = 32'(state_led);
      4:       actual = 32'(wrap);
      5:       actual = 32'(lap_data);
      6:       actual = 32'(lap_count);
      7:       actual = 32'(lap_empty);
      8:       actual = 32'(lap_full);
      10:      actual = 32'(digits2);
      11:      actual = 32'(wrap2);
      default: actual = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every queued expectation mid-cycle, away from the clock edge.
  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        act = actual(cur.sel);
        n_checks++;
        if (act !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] c);
    cmd2_valid = 1'b1;
    cmd2       = c;
    @(posedge clock); #1;
    cmd2_valid = 1'b0;
  endtask

  task automatic pop_lap();
    lap_rd = 1'b1;
    @(posedge clock); #1;
    lap_rd = 1'b0;
  endtask

  task automatic expect_reset(input string tag);
    expect_v({tag, "_digits"}, 0, 32'h0);
    expect_v({tag, "_seg"},    1, 32'(SEG_ZERO));
    expect_v({tag, "_state"},  2, 32'd0);
    expect_v({tag, "_led"},    3, 32'b0001);
    expect_v({tag, "_wrap"},   4, 32'd0);
    expect_v({tag, "_ldata"},  5, 32'h0);
    expect_v({tag, "_lcount"}, 6, 32'd0);
    expect_v({tag, "_lempty"}, 7, 32'd1);
    expect_v({tag, "_lfull"},  8, 32'd0);
    expect_v({tag, "_dig2"},  10, 32'h0);
  endtask

  logic [15:0] laps [4];

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; lap_rd = 1'b0;
    cmd2_valid = 1'b0; cmd2 = 2'd0; lap_rd2 = 1'b0;
    tick_n(2);
    expect_reset("rst");
    tick_n(1);
    reset_n = 1'b1;
    tick_n(1);

    // Commands other than RUN are ignored in CLEAR.
    send(ST_STOP);
    expect_v("clr_ign_stop", 2, 32'd0);
    send(ST_HOLD);
    expect_v("clr_ign_hold", 2, 32'd0);
    expect_v("clr_ign_led",  3, 32'b0001);

    // Rollover on the 2-digit instance: 99 ticks then one more.
    send2(ST_RUN);
    tick_n(990);
    expect_v("w_99",    10, 32'h99);
    expect_v("w_pre0",  11, 32'd0);
    tick_n(9);
    expect_v("w_pre1",  11, 32'd0);
    tick_n(1);
    expect_v("w_zero",  10, 32'h00);
    expect_v("w_pulse", 11, 32'd1);
    tick_n(1);
    expect_v("w_post",  11, 32'd0);
    tick_n(9);
    expect_v("w_cont",  10, 32'h01);
    send2(ST_STOP);

    // 250 cycles of RUN = 25 ticks.
    send(ST_RUN);
    tick_n(250);
    expect_v("run25_dig", 0, 32'h0025);
    expect_v("run25_led", 3, 32'b0010);
    expect_v("run25_st",  2, 32'd1);
    expect_v("run25_seg", 1, 32'({7'h40, 7'h40, 7'h24, 7'h12}));

    // HOLD at 0012 freezes display while counting continues.
    send(ST_CLEAR);
    expect_v("clr_dig", 0, 32'h0);
    expect_v("clr_st",  2, 32'd0);
    send(ST_RUN);
    tick_n(120);
    send(ST_HOLD);
    expect_v("hold_dig", 0, 32'h0012);
    expect_v("hold_st",  2, 32'd2);
    expect_v("hold_led", 3, 32'b0100);
`ifdef SW_CHRONO_LAP_FIFO_EN
    expect_v("hold_ldata",  5, 32'h0012);
    expect_v("hold_lcount", 6, 32'd1);
`else
    expect_v("hold_ldata",  5, 32'h0);
    expect_v("hold_lcount", 6, 32'd0);
`endif
    tick_n(50);
    expect_v("hold_frozen", 0, 32'h0012);
    send(ST_RUN);
    expect_v("resume_dig", 0, 32'h0017);

    // STOP at 0030; HOLD/STOP ignored; CLEAR resets.
    tick_n(128);
    expect_v("pre_stop", 0, 32'h0030);
    send(ST_STOP);
    send(ST_HOLD);
    send(ST_STOP);
    tick_n(100);
    expect_v("stop_st",  2, 32'd3);
    expect_v("stop_led", 3, 32'b1000);
    expect_v("stop_dig", 0, 32'h0030);
    expect_v("stop_seg", 1, 32'({7'h40, 7'h40, 7'h30, 7'h40}));
    send(ST_CLEAR);
    expect_v("clr2_dig",    0, 32'h0);
    expect_v("clr2_seg",    1, 32'(SEG_ZERO));
    expect_v("clr2_st",     2, 32'd0);
    expect_v("clr2_lcount", 6, 32'd0);
    expect_v("clr2_lempty", 7, 32'd1);

    // Five laps captured at 2,4,6,8,10; the fifth is dropped when full.
    send(ST_RUN);
    tick_n(2);
    for (int i = 0; i < 5; i++) begin
      tick_n(18);
      send(ST_HOLD);
      send(ST_RUN);
    end
`ifdef SW_CHRONO_LAP_FIFO_EN
    expect_v("fifo_full",   8, 32'd1);
    expect_v("fifo_count",  6, 32'd4);
    expect_v("fifo_head",   5, 32'h0002);
`else
    expect_v("fifo_full",   8, 32'd0);
    expect_v("fifo_count",  6, 32'd0);
    expect_v("fifo_head",   5, 32'h0);
`endif
    // Push (lap 0011) and pop together while full.
    tick_n(17);
    cmd_valid = 1'b1; cmd = ST_HOLD; lap_rd = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0; lap_rd = 1'b0;
    send(ST_RUN);
`ifdef SW_CHRONO_LAP_FIFO_EN
    expect_v("pp_count", 6, 32'd4);
    expect_v("pp_full",  8, 32'd1);
    laps[0] = 16'h0004; laps[1] = 16'h0006; laps[2] = 16'h0008; laps[3] = 16'h0011;
`else
    expect_v("pp_count", 6, 32'd0);
    expect_v("pp_full",  8, 32'd0);
    laps[0] = 16'h0; laps[1] = 16'h0; laps[2] = 16'h0; laps[3] = 16'h0;
`endif
    for (int j = 0; j < 4; j++) begin
      expect_v($sformatf("lap%0d", j), 5, 32'(laps[j]));
      pop_lap();
    end
    expect_v("drain_empty", 7, 32'd1);
    expect_v("drain_count", 6, 32'd0);
    pop_lap();
    expect_v("over_empty", 7, 32'd1);
    expect_v("over_count", 6, 32'd0);
    expect_v("over_data",  5, 32'h0);

    // Asynchronous reset mid-RUN at 0042.
    send(ST_CLEAR);
    send(ST_RUN);
    tick_n(420);
    expect_v("pre_rst", 0, 32'h0042);
    tick_n(1);
    reset_n = 1'b0;
    expect_reset("arst");
    tick_n(2);
    reset_n = 1'b1;
    tick_n(1);
    expect_v("post_rst_st",  2, 32'd0);
    expect_v("post_rst_dig", 0, 32'h0);

    @(negedge clock); #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
